// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle RISC-V sequencing controller. It
// holds the following:
//   - the FSM state enumeration
//   - the opcode constants recognised in DECODE
//   - the output encodings for ALUControl, ResultSrc, ALUSrcA, ALUSrcB and
//     ImmSrc
//   - the ALU-decoder class enumeration
//   - the opcode-to-immediate-format helper
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALR2    = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    // Selects which decode table the ALU decoder applies.
    typedef enum logic [2:0] {
        CLS_ADD    = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ITYPE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JALR   = 3'd4
    } alu_cls_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_ITYPE  = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_LUI    = 7'd55;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format purely from the opcode. Unknown opcodes fall back to
    // the I format, which is harmless because they never reach a write.
    function automatic logic [2:0] imm_src(input logic [6:0] opc);
        case (opc)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_alu_decoder
// Combinational map from (decode class, funct3, funct7) to the ALU
// operation. It also produces an illegal flag for funct combinations that
// the core does not implement.
// Ports:
//   i_cls       decode table to apply (see alu_cls_t)
//   i_f3        funct3 field
//   i_f7        funct7 field
//   o_alu_ctl   ALU operation encoding
//   o_illegal   1 when (i_cls, i_f3, i_f7) is not a supported encoding
// ---------------------------------------------------------------------------
module mc_alu_decoder
    import mc_pkg::*;
(
    input  alu_cls_t   i_cls,
    input  logic [2:0] i_f3,
    input  logic [6:0] i_f7,
    output logic [2:0] o_alu_ctl,
    output logic       o_illegal
);

    always_comb begin
        o_alu_ctl = ALU_ADD;
        o_illegal = 1'b0;
        case (i_cls)
            CLS_RTYPE: begin
                case ({i_f3, i_f7})
                    {3'd0, 7'd0}:  o_alu_ctl = ALU_ADD;
                    {3'd0, 7'd32}: o_alu_ctl = ALU_SUB;
                    {3'd7, 7'd0}:  o_alu_ctl = ALU_AND;
                    {3'd6, 7'd0}:  o_alu_ctl = ALU_OR;
                    {3'd2, 7'd0}:  o_alu_ctl = ALU_SLT;
                    {3'd3, 7'd0}:  o_alu_ctl = ALU_SLTU;
                    default:       o_illegal = 1'b1;
                endcase
            end
            CLS_ITYPE: begin
                // Immediate ops ignore funct7.
                case (i_f3)
                    3'd0:    o_alu_ctl = ALU_ADD;
                    3'd4:    o_alu_ctl = ALU_XOR;
                    3'd6:    o_alu_ctl = ALU_OR;
                    3'd2:    o_alu_ctl = ALU_SLT;
                    3'd3:    o_alu_ctl = ALU_SLTU;
                    default: o_illegal = 1'b1;
                endcase
            end
            CLS_BRANCH: begin
                // Branches compare by subtraction; only beq/bne/blt/bge exist.
                o_alu_ctl = ALU_SUB;
                case (i_f3)
                    3'd0, 3'd1, 3'd4, 3'd5: o_illegal = 1'b0;
                    default:                o_illegal = 1'b1;
                endcase
            end
            CLS_JALR: begin
                o_illegal = (i_f3 != 3'd0);
            end
            default: begin
                o_alu_ctl = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Sequencing FSM for the multi-cycle RISC-V core. It steps the shared ALU
// and the unified memory through fetch, decode, execute, memory and
// writeback for each instruction.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   opc, f3, f7          instruction fields from the instruction register
//   zero, lt             ALU flags used to resolve branches
//   mem_ready            memory completes the current access this cycle
//   PCWrite, IRWrite     PC load enable, instruction/OldPC load enable
//   AdrSrc, MemWrite     memory address select, memory write request
//   RegWrite             register file write enable
//   ResultSrc            result mux select
//   ALUSrcA, ALUSrcB     ALU operand selects
//   ALUControl           ALU operation
//   ImmSrc               immediate format (decoded from opc in every state)
//   illegal              one-cycle pulse in DECODE for unsupported encodings
// ---------------------------------------------------------------------------
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    alu_cls_t   w_cls;
    logic [2:0] w_dec_alu;
    logic       w_dec_illegal;
    logic       w_opc_known;
    logic       w_illegal;
    logic       w_taken;

    // In DECODE the decoder is driven from the opcode so that funct
    // legality is known before committing to an execute state. In the
    // execute states it is driven from the state itself.
    always_comb begin
        w_cls       = CLS_ADD;
        w_opc_known = 1'b1;
        case (opc)
            OP_LOAD, OP_STORE, OP_JAL, OP_LUI: w_opc_known = 1'b1;
            OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JALR: w_opc_known = 1'b1;
            default: w_opc_known = 1'b0;
        endcase
        case (r_state)
            S_EXECR:  w_cls = CLS_RTYPE;
            S_EXECI:  w_cls = CLS_ITYPE;
            S_BRANCH: w_cls = CLS_BRANCH;
            S_DECODE: begin
                case (opc)
                    OP_RTYPE:  w_cls = CLS_RTYPE;
                    OP_ITYPE:  w_cls = CLS_ITYPE;
                    OP_BRANCH: w_cls = CLS_BRANCH;
                    OP_JALR:   w_cls = CLS_JALR;
                    default:   w_cls = CLS_ADD;
                endcase
            end
            default: w_cls = CLS_ADD;
        endcase
    end

    mc_alu_decoder u_alu_dec (
        .i_cls     (w_cls),
        .i_f3      (f3),
        .i_f7      (f7),
        .o_alu_ctl (w_dec_alu),
        .o_illegal (w_dec_illegal)
    );

    assign w_illegal = (r_state == S_DECODE) && (!w_opc_known || w_dec_illegal);

    // Branch resolution (Mealy term in BRANCH).
    always_comb begin
        case (f3)
            3'd0:    w_taken = zero;
            3'd1:    w_taken = !zero;
            3'd4:    w_taken = lt;
            3'd5:    w_taken = !lt;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_illegal) begin
                    w_next = S_FETCH;
                end else begin
                    case (opc)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:          w_next = S_EXECR;
                        OP_ITYPE:          w_next = S_EXECI;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR;
                        OP_BRANCH:         w_next = S_BRANCH;
                        OP_LUI:            w_next = S_LUI;
                        default:           w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   w_next = (opc == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_JALR2;
            S_JALR2:    w_next = S_ALUWB;
            S_BRANCH:   w_next = S_FETCH;
            S_LUI:      w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Outputs. The write enables are gated by rst_n so that nothing is
    // written while reset is held, even though FETCH enables follow
    // mem_ready.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        ImmSrc     = imm_src(opc);
        illegal    = w_illegal & rst_n;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready & rst_n;
                PCWrite   = mem_ready & rst_n;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = rst_n;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = rst_n;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUControl = w_dec_alu;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = w_dec_alu;
            end
            S_ALUWB: begin
                RegWrite = rst_n;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = rst_n;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUControl = w_dec_alu;
                PCWrite    = w_taken & rst_n;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                RegWrite  = rst_n;
            end
            default: begin
                ResultSrc = RES_ALUOUT;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for the multi-cycle controller. All outputs are packed into
// one 18-bit vector and compared each cycle against hand-built expectations.
// Packing order:
//   {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//    ALUSrcB, ALUControl, ImmSrc, illegal}
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int         n_checks;
    int         n_fail;
    logic [2:0] imm_exp;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opc        (opc),
        .f3         (f3),
        .f7         (f7),
        .zero       (zero),
        .lt         (lt),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] w_out;
    assign w_out = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

    function automatic logic [17:0] ov(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm_exp, ill};
    endfunction

    // Expected output vectors per state.
    function automatic logic [17:0] e_fetch(input logic mr);
        return ov(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_reset();
        return ov(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_dec(input logic ill);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, ill);
    endfunction
    function automatic logic [17:0] e_madr();
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_mread();
        return ov(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_mwb();
        return ov(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_mwrite();
        return ov(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_execr(input logic [2:0] alu);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0);
    endfunction
    function automatic logic [17:0] e_execi(input logic [2:0] alu);
        return ov(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0);
    endfunction
    function automatic logic [17:0] e_aluwb();
        return ov(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_jal();
        return ov(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [17:0] e_branch(input logic tk);
        return ov(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    endfunction
    function automatic logic [17:0] e_lui();
        return ov(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 0);
    endfunction

    task automatic check(input string tag, input logic [17:0] obs,
                         input logic [17:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b", tag, obs, exp);
        end
    endtask

    // Check the current cycle away from the edge, then advance one clock.
    task automatic step(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check(tag, w_out, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] a,
                             input logic [6:0] b, input logic [2:0] im);
        opc     = o;
        f3      = a;
        f7      = b;
        imm_exp = im;
    endtask

    logic [2:0] br_f3 [4];
    logic       br_z  [4];
    logic       br_lt [4];
    logic       br_tk [4];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        lt        = 1'b0;
        set_instr(7'd0, 3'd0, 7'd0, 3'b000);
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5};
        br_z  = '{1'b1, 1'b1, 1'b0, 1'b0};
        br_lt = '{1'b0, 1'b0, 1'b1, 1'b1};
        br_tk = '{1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", w_out, e_reset());
        rst_n = 1'b1;

        // lw, no stalls: 5 cycles.
        set_instr(7'd3, 3'd2, 7'd0, 3'b000);
        step("lw_fetch", e_fetch(1));
        step("lw_decode", e_dec(0));
        step("lw_memadr", e_madr());
        step("lw_memread", e_mread());
        step("lw_memwb", e_mwb());

        // sw with three stall cycles in MEMWRITE.
        set_instr(7'd35, 3'd2, 7'd0, 3'b001);
        step("sw_fetch", e_fetch(1));
        step("sw_decode", e_dec(0));
        mem_ready = 1'b0;
        step("sw_memadr", e_madr());
        step("sw_mw_stall0", e_mwrite());
        step("sw_mw_stall1", e_mwrite());
        step("sw_mw_stall2", e_mwrite());
        mem_ready = 1'b1;
        step("sw_mw_done", e_mwrite());

        // Branches, 3 cycles each.
        for (int i = 0; i < 4; i++) begin
            set_instr(7'd99, br_f3[i], 7'd0, 3'b010);
            zero = br_z[i];
            lt   = br_lt[i];
            step($sformatf("br%0d_fetch", i), e_fetch(1));
            step($sformatf("br%0d_decode", i), e_dec(0));
            step($sformatf("br%0d_branch", i), e_branch(br_tk[i]));
        end
        zero = 1'b0;
        lt   = 1'b0;

        // R-type sub.
        set_instr(7'd51, 3'd0, 7'd32, 3'b000);
        step("sub_fetch", e_fetch(1));
        step("sub_decode", e_dec(0));
        step("sub_execr", e_execr(3'b001));
        step("sub_aluwb", e_aluwb());

        // R-type with bad funct7: illegal pulse, straight back to FETCH.
        set_instr(7'd51, 3'd0, 7'd1, 3'b000);
        step("rbad_fetch", e_fetch(1));
        step("rbad_decode", e_dec(1));

        // Unknown opcode.
        set_instr(7'd127, 3'd0, 7'd0, 3'b000);
        step("opbad_fetch", e_fetch(1));
        step("opbad_decode", e_dec(1));

        // xori, then an unsupported I-type funct3.
        set_instr(7'd19, 3'd4, 7'd0, 3'b000);
        step("xori_fetch", e_fetch(1));
        step("xori_decode", e_dec(0));
        step("xori_execi", e_execi(3'b100));
        step("xori_aluwb", e_aluwb());
        set_instr(7'd19, 3'd1, 7'd0, 3'b000);
        step("ibad_fetch", e_fetch(1));
        step("ibad_decode", e_dec(1));

        // jalr: 5 cycles.
        set_instr(7'd103, 3'd0, 7'd0, 3'b000);
        step("jalr_fetch", e_fetch(1));
        step("jalr_decode", e_dec(0));
        step("jalr_jalr", e_madr());
        step("jalr_jalr2", e_jal());
        step("jalr_aluwb", e_aluwb());

        // jalr with f3 != 0 is illegal.
        set_instr(7'd103, 3'd1, 7'd0, 3'b000);
        step("jalrbad_fetch", e_fetch(1));
        step("jalrbad_decode", e_dec(1));

        // jal: 4 cycles.
        set_instr(7'd111, 3'd0, 7'd0, 3'b011);
        step("jal_fetch", e_fetch(1));
        step("jal_decode", e_dec(0));
        step("jal_jal", e_jal());
        step("jal_aluwb", e_aluwb());

        // lui: 3 cycles.
        set_instr(7'd55, 3'd0, 7'd0, 3'b100);
        step("lui_fetch", e_fetch(1));
        step("lui_decode", e_dec(0));
        step("lui_lui", e_lui());

        // Fetch stall then lw with a MEMREAD stall.
        set_instr(7'd3, 3'd2, 7'd0, 3'b000);
        mem_ready = 1'b0;
        step("lws_fetch_stall", e_fetch(0));
        mem_ready = 1'b1;
        step("lws_fetch", e_fetch(1));
        step("lws_decode", e_dec(0));
        mem_ready = 1'b0;
        step("lws_memadr", e_madr());
        step("lws_memread_stall", e_mread());
        mem_ready = 1'b1;
        step("lws_memread", e_mread());
        step("lws_memwb", e_mwb());

        // Reset asserted in the middle of a MEMWRITE stall.
        set_instr(7'd35, 3'd2, 7'd0, 3'b001);
        step("swr_fetch", e_fetch(1));
        step("swr_decode", e_dec(0));
        mem_ready = 1'b0;
        step("swr_memadr", e_madr());
        @(negedge clk);
        check("swr_memwrite", w_out, e_mwrite());
        mem_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("swr_async_reset", w_out, e_reset());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("swr_fetch_resume", e_fetch(1));
        step("swr_decode_resume", e_dec(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
